// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types and defaults for the dcache request arbiter.
// Included by the arbiter top and its aging-counter sub-module.
package dcache_req_arbiter_pkg;

    localparam int DCACHE_ARB_ADDR_W        = 32;
    localparam int DCACHE_ARB_DATA_W        = 32;
    localparam int DCACHE_ARB_SEL_W         = DCACHE_ARB_DATA_W / 8;
    localparam int DCACHE_ARB_LD_STREAK_MAX = 4;
    localparam int DCACHE_ARB_STREAK_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        LD_KILL
    } type_dcache_arb_state_e;

    typedef struct packed {
        logic                         req;
        logic [DCACHE_ARB_ADDR_W-1:0] addr;
    } type_lsu2dcache_ld_s;

    typedef struct packed {
        logic                         req;
        logic [DCACHE_ARB_ADDR_W-1:0] addr;
        logic [DCACHE_ARB_DATA_W-1:0] wdata;
        logic [DCACHE_ARB_SEL_W-1:0]  sel;
    } type_sb2dcache_st_s;

    typedef struct packed {
        logic                         req;
        logic                         w_en;
        logic [DCACHE_ARB_ADDR_W-1:0] addr;
        logic [DCACHE_ARB_DATA_W-1:0] wdata;
        logic [DCACHE_ARB_SEL_W-1:0]  sel;
    } type_arb2dcache_s;

endpackage

// File: rtl/dcache_arb_streak_cnt.sv
// Load-streak aging counter: counts load grants made while a store waits.
// sat asserts once the streak reaches MAX so the waiting store is promoted.
module dcache_arb_streak_cnt
    import dcache_req_arbiter_pkg::*;
#(
    parameter int MAX = DCACHE_ARB_LD_STREAK_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    logic [DCACHE_ARB_STREAK_W-1:0] cnt;

    assign sat = (cnt == DCACHE_ARB_STREAK_W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Single-port dcache arbiter between the LSU load path and store-buffer drain.
// Optional store aging (load-streak limit) is enabled by ARB_STORE_AGE_EN.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int ADDR_W          = DCACHE_ARB_ADDR_W,
    parameter int DATA_W          = DCACHE_ARB_DATA_W,
    parameter int MAX_LOAD_STREAK = DCACHE_ARB_LD_STREAK_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_req_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    output logic                ld_ack_o,
    output logic [DATA_W-1:0]   ld_rdata_o,
    input  logic                st_req_i,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_wdata_i,
    input  logic [DATA_W/8-1:0] st_sel_i,
    output logic                st_ack_o,
    input  logic                sb_full_i,
    input  logic                lsu_flush_i,
    output logic                dc_req_o,
    output logic                dc_w_en_o,
    output logic [ADDR_W-1:0]   dc_addr_o,
    output logic [DATA_W-1:0]   dc_wdata_o,
    output logic [DATA_W/8-1:0] dc_sel_o,
    input  logic                dc_ack_i,
    input  logic [DATA_W-1:0]   dc_rdata_i
);

    localparam int SEL_W = DATA_W / 8;

    // The streak counter is 3 bits wide, so the limit must fit in it.
    if (MAX_LOAD_STREAK < 1 || MAX_LOAD_STREAK > 7) begin : g_bad_streak
        $error("MAX_LOAD_STREAK must be in 1..7");
    end

    type_dcache_arb_state_e state;

    logic idle;
    logic same_word;
    logic ld_go;
    logic st_first;
    logic grant_ld;
    logic grant_st;
    logic promote;

    assign idle      = (state == IDLE);
    assign same_word = (ld_addr_i[ADDR_W-1:2] == st_addr_i[ADDR_W-1:2]);
    assign ld_go     = ld_req_i & ~lsu_flush_i;

    // Full buffer, same-word hazard and an aged store all beat a pending load.
    assign st_first = st_req_i & (sb_full_i | (ld_req_i & same_word) | promote);
    assign grant_st = idle & (st_first | (st_req_i & ~ld_go));
    assign grant_ld = idle & ld_go & ~st_first;

`ifdef ARB_STORE_AGE_EN
    dcache_arb_streak_cnt #(
        .MAX (MAX_LOAD_STREAK)
    ) u_streak (
        .clk (clk),
        .rst (rst),
        .clr (grant_st | (idle & ~st_req_i)),
        .inc (grant_ld & st_req_i),
        .sat (promote)
    );
`else
    assign promote = 1'b0;
`endif

    assign ld_ack_o   = (state == LOAD) & dc_ack_i & ~lsu_flush_i;
    assign ld_rdata_o = ld_ack_o ? dc_rdata_i : '0;
    assign st_ack_o   = (state == STORE) & dc_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dc_req_o   <= 1'b0;
            dc_w_en_o  <= 1'b0;
            dc_addr_o  <= '0;
            dc_wdata_o <= '0;
            dc_sel_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_st) begin
                        state      <= STORE;
                        dc_req_o   <= 1'b1;
                        dc_w_en_o  <= 1'b1;
                        dc_addr_o  <= st_addr_i;
                        dc_wdata_o <= st_wdata_i;
                        dc_sel_o   <= st_sel_i;
                    end else if (grant_ld) begin
                        state      <= LOAD;
                        dc_req_o   <= 1'b1;
                        dc_w_en_o  <= 1'b0;
                        dc_addr_o  <= ld_addr_i;
                        dc_wdata_o <= '0;
                        dc_sel_o   <= {SEL_W{1'b1}};
                    end
                end
                LOAD: begin
                    if (dc_ack_i) begin
                        state    <= IDLE;
                        dc_req_o <= 1'b0;
                    end else if (lsu_flush_i) begin
                        state <= LD_KILL;
                    end
                end
                STORE: begin
                    if (dc_ack_i) begin
                        state     <= IDLE;
                        dc_req_o  <= 1'b0;
                        dc_w_en_o <= 1'b0;
                    end
                end
                LD_KILL: begin
                    // The cache cannot abort; wait out the ack and drop the data.
                    if (dc_ack_i) begin
                        state    <= IDLE;
                        dc_req_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed self-checking bench for dcache_req_arbiter.
// Expected streak behaviour follows ARB_STORE_AGE_EN at compile time.
module tb_dcache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req_i;
    logic [31:0] ld_addr_i;
    logic        ld_ack_o;
    logic [31:0] ld_rdata_o;
    logic        st_req_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_wdata_i;
    logic [3:0]  st_sel_i;
    logic        st_ack_o;
    logic        sb_full_i;
    logic        lsu_flush_i;
    logic        dc_req_o;
    logic        dc_w_en_o;
    logic [31:0] dc_addr_o;
    logic [31:0] dc_wdata_o;
    logic [3:0]  dc_sel_o;
    logic        dc_ack_i;
    logic [31:0] dc_rdata_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_req_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_ack_o    (ld_ack_o),
        .ld_rdata_o  (ld_rdata_o),
        .st_req_i    (st_req_i),
        .st_addr_i   (st_addr_i),
        .st_wdata_i  (st_wdata_i),
        .st_sel_i    (st_sel_i),
        .st_ack_o    (st_ack_o),
        .sb_full_i   (sb_full_i),
        .lsu_flush_i (lsu_flush_i),
        .dc_req_o    (dc_req_o),
        .dc_w_en_o   (dc_w_en_o),
        .dc_addr_o   (dc_addr_o),
        .dc_wdata_o  (dc_wdata_o),
        .dc_sel_o    (dc_sel_o),
        .dc_ack_i    (dc_ack_i),
        .dc_rdata_i  (dc_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are stable before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        ld_req_i    = 1'b0;
        ld_addr_i   = '0;
        st_req_i    = 1'b0;
        st_addr_i   = '0;
        st_wdata_i  = '0;
        st_sel_i    = '0;
        sb_full_i   = 1'b0;
        lsu_flush_i = 1'b0;
        dc_ack_i    = 1'b0;
        dc_rdata_i  = '0;
        tick();
        tick();
        chk("rst_dc_req", dc_req_o, 0);
        chk("rst_w_en", dc_w_en_o, 0);
        chk("rst_addr", dc_addr_o, 0);
        chk("rst_sel", dc_sel_o, 0);
        chk("rst_ld_ack", ld_ack_o, 0);
        chk("rst_st_ack", st_ack_o, 0);
        rst = 1'b0;
        tick();

        // Load only
        ld_req_i  = 1'b1;
        ld_addr_i = 32'h100;
        tick();
        chk("ld_dc_req", dc_req_o, 1);
        chk("ld_w_en", dc_w_en_o, 0);
        chk("ld_addr", dc_addr_o, 32'h100);
        chk("ld_sel", dc_sel_o, 4'hF);
        tick();
        chk("ld_hold_req", dc_req_o, 1);
        chk("ld_no_early_ack", ld_ack_o, 0);
        dc_ack_i   = 1'b1;
        dc_rdata_i = 32'hDEADBEEF;
        #1;
        chk("ld_ack", ld_ack_o, 1);
        chk("ld_rdata", ld_rdata_o, 32'hDEADBEEF);
        tick();
        ld_req_i = 1'b0;
        dc_ack_i = 1'b0;
        chk("ld_done_req", dc_req_o, 0);
        chk("ld_done_ack", ld_ack_o, 0);

        // Load and store, different words: load first
        ld_req_i   = 1'b1;
        ld_addr_i  = 32'h200;
        st_req_i   = 1'b1;
        st_addr_i  = 32'h300;
        st_wdata_i = 32'hCAFEF00D;
        st_sel_i   = 4'b0011;
        tick();
        chk("ls_first_w_en", dc_w_en_o, 0);
        chk("ls_first_addr", dc_addr_o, 32'h200);
        dc_ack_i   = 1'b1;
        dc_rdata_i = 32'h11112222;
        #1;
        chk("ls_ld_ack", ld_ack_o, 1);
        chk("ls_no_st_ack", st_ack_o, 0);
        tick();
        ld_req_i = 1'b0;
        dc_ack_i = 1'b0;
        chk("ls_gap_req", dc_req_o, 0);
        tick();
        chk("ls_st_req", dc_req_o, 1);
        chk("ls_st_w_en", dc_w_en_o, 1);
        chk("ls_st_addr", dc_addr_o, 32'h300);
        chk("ls_st_wdata", dc_wdata_o, 32'hCAFEF00D);
        chk("ls_st_sel", dc_sel_o, 4'b0011);
        dc_ack_i = 1'b1;
        #1;
        chk("ls_st_ack", st_ack_o, 1);
        chk("ls_st_no_ld_ack", ld_ack_o, 0);
        tick();
        st_req_i = 1'b0;
        dc_ack_i = 1'b0;
        chk("ls_st_done", dc_req_o, 0);

        // Same-word hazard: store first
        ld_req_i  = 1'b1;
        ld_addr_i = 32'h404;
        st_req_i  = 1'b1;
        st_addr_i = 32'h405;
        tick();
        chk("hz_w_en", dc_w_en_o, 1);
        chk("hz_addr", dc_addr_o, 32'h405);
        dc_ack_i = 1'b1;
        #1;
        chk("hz_st_ack", st_ack_o, 1);
        tick();
        st_req_i = 1'b0;
        dc_ack_i = 1'b0;
        tick();
        chk("hz_ld_w_en", dc_w_en_o, 0);
        chk("hz_ld_addr", dc_addr_o, 32'h404);
        dc_ack_i = 1'b1;
        #1;
        chk("hz_ld_ack", ld_ack_o, 1);
        tick();
        ld_req_i = 1'b0;
        dc_ack_i = 1'b0;

        // Flush one cycle after grant, ack three cycles later
        ld_req_i  = 1'b1;
        ld_addr_i = 32'h500;
        tick();
        chk("fl_req", dc_req_o, 1);
        tick();
        lsu_flush_i = 1'b1;
        ld_req_i    = 1'b0;
        tick();
        lsu_flush_i = 1'b0;
        chk("fl_kill_req", dc_req_o, 1);
        tick();
        chk("fl_kill_addr", dc_addr_o, 32'h500);
        tick();
        dc_ack_i   = 1'b1;
        dc_rdata_i = 32'h55555555;
        #1;
        chk("fl_no_ack", ld_ack_o, 0);
        chk("fl_ack_cycle_req", dc_req_o, 1);
        tick();
        dc_ack_i = 1'b0;
        chk("fl_idle_req", dc_req_o, 0);

        // Flush and ack in the same cycle
        ld_req_i  = 1'b1;
        ld_addr_i = 32'h600;
        tick();
        lsu_flush_i = 1'b1;
        dc_ack_i    = 1'b1;
        #1;
        chk("fa_no_ack", ld_ack_o, 0);
        chk("fa_rdata", ld_rdata_o, 0);
        tick();
        lsu_flush_i = 1'b0;
        ld_req_i    = 1'b0;
        dc_ack_i    = 1'b0;
        chk("fa_idle_req", dc_req_o, 0);

        // Ack while idle is ignored
        dc_ack_i = 1'b1;
        #1;
        chk("ia_ld_ack", ld_ack_o, 0);
        chk("ia_st_ack", st_ack_o, 0);
        tick();
        dc_ack_i = 1'b0;
        chk("ia_req", dc_req_o, 0);

        // Continuous loads with a pending store on another word
        ld_req_i  = 1'b1;
        ld_addr_i = 32'h700;
        st_req_i  = 1'b1;
        st_addr_i = 32'h800;
        for (int i = 0; i < 5; i++) begin
            logic exp_w;
`ifdef ARB_STORE_AGE_EN
            exp_w = (i == 4);
`else
            exp_w = 1'b0;
`endif
            tick();
            chk($sformatf("streak_w_en_%0d", i), dc_w_en_o, exp_w);
            chk($sformatf("streak_req_%0d", i), dc_req_o, 1);
            dc_ack_i = 1'b1;
            tick();
            dc_ack_i = 1'b0;
        end
`ifndef ARB_STORE_AGE_EN
        sb_full_i = 1'b1;
        tick();
        chk("full_w_en", dc_w_en_o, 1);
        chk("full_addr", dc_addr_o, 32'h800);
        dc_ack_i = 1'b1;
        #1;
        chk("full_st_ack", st_ack_o, 1);
        tick();
        dc_ack_i  = 1'b0;
        sb_full_i = 1'b0;
`endif
        ld_req_i = 1'b0;
        st_req_i = 1'b0;
        tick();
        tick();
        chk("streak_idle", dc_req_o, 0);

        // Reset asserted mid-store
        st_req_i  = 1'b1;
        st_addr_i = 32'h900;
        tick();
        chk("rs_req", dc_req_o, 1);
        chk("rs_w_en", dc_w_en_o, 1);
        dc_ack_i = 1'b1;
        rst      = 1'b1;
        #1;
        chk("rs_req_clear", dc_req_o, 0);
        chk("rs_w_en_clear", dc_w_en_o, 0);
        chk("rs_st_ack", st_ack_o, 0);
        chk("rs_addr_clear", dc_addr_o, 0);
        st_req_i = 1'b0;
        #1;
        rst      = 1'b0;
        dc_ack_i = 1'b0;
        tick();
        chk("rs_idle_req", dc_req_o, 0);
        chk("rs_idle_ack", st_ack_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
